// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - four-channel countdown timer scheduler sharing one tick prescaler (optional TIMER_SCHED_PERIODIC_EN)
module timer_sched #(
    parameter int JIFFIES = 100_000_000,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [1:0]       req_ch,
    input  logic [LEN_W-1:0] req_len,
`ifdef TIMER_SCHED_PERIODIC_EN
    input  logic             req_periodic,
`endif
    output logic             req_ready,
    input  logic [3:0]       cancel,
    output logic [3:0]       busy,
    output logic [3:0]       done,
    output logic             tick
);

    localparam logic [31:0]      PCOUNT_LAST = 32'(JIFFIES - 1);
    localparam logic [LEN_W-1:0] REM_ONE     = LEN_W'(1);

    logic [31:0]      pcount_q, pcount_d;
    logic [3:0]       busy_q, busy_d;
    logic [3:0]       done_q, done_d;
    logic [LEN_W-1:0] rem_q [4];
    logic [LEN_W-1:0] rem_d [4];
`ifdef TIMER_SCHED_PERIODIC_EN
    logic [LEN_W-1:0] reload_q [4];
    logic [LEN_W-1:0] reload_d [4];
    logic [3:0]       periodic_q, periodic_d;
`endif

    logic load_acc;

    // Ready and tick are decodes of registered state only
    assign req_ready = !busy_q[req_ch];
    assign tick      = (|busy_q) && (pcount_q == PCOUNT_LAST);
    assign busy      = busy_q;
    assign done      = done_q;
    assign load_acc  = req_valid && req_ready;

    // Per-channel next state: cancel beats a final tick; loads only ever land on idle channels
    always_comb begin
        busy_d = busy_q;
        done_d = '0;
        rem_d  = rem_q;
`ifdef TIMER_SCHED_PERIODIC_EN
        reload_d   = reload_q;
        periodic_d = periodic_q;
`endif
        for (int i = 0; i < 4; i++) begin
            if (cancel[i] && busy_q[i]) begin
                busy_d[i] = 1'b0;
                rem_d[i]  = '0;
            end else if (busy_q[i] && tick) begin
                if (rem_q[i] > REM_ONE) begin
                    rem_d[i] = rem_q[i] - REM_ONE;
                end else begin
                    done_d[i] = 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
                    if (periodic_q[i]) begin
                        rem_d[i] = reload_q[i];
                    end else begin
                        busy_d[i] = 1'b0;
                        rem_d[i]  = '0;
                    end
`else
                    busy_d[i] = 1'b0;
                    rem_d[i]  = '0;
`endif
                end
            end
            if (load_acc && (req_ch == 2'(i))) begin
                if (req_len == '0) begin
                    done_d[i] = 1'b1;
                end else begin
                    busy_d[i] = 1'b1;
                    rem_d[i]  = req_len;
`ifdef TIMER_SCHED_PERIODIC_EN
                    reload_d[i]   = req_len;
                    periodic_d[i] = req_periodic;
`endif
                end
            end
        end
    end

    // Shared prescaler: runs only while something counts, parks at 0 once everything is idle
    always_comb begin
        pcount_d = pcount_q;
        if ((busy_d == 4'b0000) || tick) begin
            pcount_d = '0;
        end else if (|busy_q) begin
            pcount_d = pcount_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcount_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                rem_q[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
                reload_q[i] <= '0;
`endif
            end
`ifdef TIMER_SCHED_PERIODIC_EN
            periodic_q <= '0;
`endif
        end else begin
            pcount_q <= pcount_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int i = 0; i < 4; i++) begin
                rem_q[i] <= rem_d[i];
`ifdef TIMER_SCHED_PERIODIC_EN
                reload_q[i] <= reload_d[i];
`endif
            end
`ifdef TIMER_SCHED_PERIODIC_EN
            periodic_q <= periodic_d;
`endif
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - randomized bench for timer_sched against a tick-schedule reference model
module tb_timer_sched;

    localparam int J     = 4;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic [1:0]       req_ch;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic [3:0]       cancel;
    logic [3:0]       busy;
    logic [3:0]       done;
    logic             tick;
`ifdef TIMER_SCHED_PERIODIC_EN
    logic             req_periodic = 1'b0;
`endif

    always #5 clk = ~clk;

    timer_sched #(.JIFFIES(J), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_len   (req_len),
`ifdef TIMER_SCHED_PERIODIC_EN
        .req_periodic(req_periodic),
`endif
        .req_ready (req_ready),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .tick      (tick)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @cycle: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: remaining ticks per channel; ticks fall every J cycles
    // counted from the first cycle of an uninterrupted run of "something busy".
    bit       m_busy [4];
    int       m_rem  [4];
    bit [3:0] m_done;
    int       cyc;
    int       run_start;

    function automatic bit [3:0] m_busy_vec();
        bit [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_tick();
        return (m_busy_vec() != 4'b0) && (((cyc - run_start + 1) % J) == 0);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 1'b0;
            m_rem[i]  = 0;
        end
        m_done = '0;
    endtask

    task automatic model_edge();
        bit [3:0] old_b;
        bit [3:0] nd;
        bit       tk;
        if (!reset_n) begin
            model_clear();
            return;
        end
        old_b = m_busy_vec();
        tk    = m_tick();
        nd    = '0;
        for (int i = 0; i < 4; i++) begin
            if (cancel[i] && m_busy[i]) begin
                m_busy[i] = 1'b0;
                m_rem[i]  = 0;
            end else if (m_busy[i] && tk) begin
                if (m_rem[i] > 1) m_rem[i]--;
                else begin
                    m_busy[i] = 1'b0;
                    m_rem[i]  = 0;
                    nd[i]     = 1'b1;
                end
            end
        end
        if (req_valid && !old_b[req_ch]) begin
            if (req_len == 0) nd[req_ch] = 1'b1;
            else begin
                m_busy[req_ch] = 1'b1;
                m_rem[req_ch]  = int'(req_len);
            end
        end
        m_done = nd;
        if ((old_b == 4'b0) && (m_busy_vec() != 4'b0)) run_start = cyc + 1;
    endtask

    initial begin
        bit [3:0] mb;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_ch    = '0;
        req_len   = '0;
        cancel    = '0;
        cyc       = 0;
        run_start = 0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        cyc = 2;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            mb = m_busy_vec();
            check("busy", 32'(busy), 32'(mb));
            check("done", 32'(done), 32'(m_done));
            check("tick", 32'(tick), 32'(m_tick()));
            if (mb == 4'b0) check("pcount_idle", dut.pcount_q, 32'd0);

            reset_n   = ($urandom % 300) != 0;
            req_valid = ($urandom % 10) < 3;
            req_ch    = 2'($urandom % 4);
            req_len   = LEN_W'($urandom_range(0, 3));
            cancel    = (($urandom % 10) == 0) ? 4'($urandom % 16) : 4'b0;
            #1;
            check("req_ready", 32'(req_ready), 32'(!mb[req_ch]));
            model_edge();
            @(posedge clk);
            cyc++;
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
# timer_sched

Four-channel countdown timer scheduler that shares one seconds-scale prescaler among independent requesters. Each requester loads a channel with a length in ticks, and the block pulses that channel's `done` after the length elapses. It sits beside the free-running slow-clock logic. Where that logic provides a single fixed-period toggle, this block provides per-requester, cancelable delays on one shared counter.

## Interface
- `JIFFIES`, default 100_000_000: `clk` cycles per tick (≥2).
- `LEN_W`, default 8: width of the tick-count length.
- `clk` in 1: system clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: load request.
- `req_ch` in 2: target channel.
- `req_len` in LEN_W: length in ticks.
- `req_periodic` in 1: auto-reload request. Present only with `TIMER_SCHED_PERIODIC_EN`.
- `req_ready` out 1: combinational, equal to `!busy[req_ch]`.
- `cancel` in 4: per-channel abort mask.
- `busy` out 4: channel is counting.
- `done` out 4: one-cycle completion pulse per channel.
- `tick` out 1: shared prescaler strobe.

## Operation
- A load is accepted when `req_valid && req_ready` at a rising edge. Channel `req_ch` then takes `remaining = req_len` and `busy = 1` from the next cycle.
- A load with `req_len = 0` is accepted. It never sets `busy`, and `done[req_ch]` pulses in the next cycle.
- A load to a busy channel is ignored (`req_ready` is low). No queueing.
- Prescaler: a 32-bit `pcount` that runs only while any channel is busy.
  - `tick = (|busy) && pcount == JIFFIES-1`. `tick` is a combinational decode of registers.
  - On `tick`, `pcount` wraps to 0. Otherwise it increments while any channel is busy.
  - When no channel is busy after the current edge's updates, `pcount` is held at 0.
- Per channel, on a `tick` edge with `busy` set and no cancel:
  - if `remaining > 1`: decrement `remaining`.
  - if `remaining == 1`: clear `busy`, pulse `done` next cycle, set `remaining` to 0.
- Channels share ticks. A channel loaded while the prescaler is already running sees its first tick after 1..JIFFIES cycles, so delay accuracy is −1/+0 tick.
- `cancel[i]` at an edge clears `busy[i]` and `remaining[i]` and suppresses that edge's `done[i]`. Cancel wins over a simultaneous final tick.
- `cancel[i]` on an idle channel has no effect. A simultaneous load to that idle channel is accepted.
- The four channels are fully independent. Any subset may complete on the same tick, giving multiple `done` bits in the same cycle.

## Timing
- Reset values: `busy = 0`, `done = 0`, `tick = 0`, `pcount = 0`, all `remaining = 0`.
- Reset mid-count aborts every channel; no `done` is emitted.
- Load accepted at edge t with the prescaler idle:
  - `busy` is high during cycles t+1 .. t+len·JIFFIES.
  - ticks occur at cycles t+k·JIFFIES.
  - `done` is high for exactly one cycle, t+len·JIFFIES+1.
- `done` and `busy` are registered. `req_ready` and `tick` are combinational from registers.
- A channel is reloadable in the cycle `done` is high, because `busy` is already low then.

## Configuration
- `TIMER_SCHED_PERIODIC_EN` defined:
  - The `req_periodic` port exists. Each channel stores a reload length and a periodic flag at load time.
  - On the final tick, a periodic channel pulses `done` next cycle, reloads `remaining`, and keeps `busy = 1`. It repeats every len·JIFFIES cycles until cancelled.
  - A periodic load with length 0 behaves as one-shot length 0.
- Not defined: the port, reload registers and flags are absent, and all channels are one-shot.

## Test plan
- `JIFFIES=4`; reset, then load ch0 len 3 at edge 10 → `busy[0]` high for cycles 11..22, ticks at 14/18/22, `done[0]` high only at cycle 23.
- Load ch2 len 0 at edge 5 → `done[2]` high at cycle 6 only, `busy[2]` never high, `tick` never asserted.
- ch0 busy; drive `req_ch=0`, `req_valid=1` → `req_ready=0`, `remaining` unchanged. Same cycle, ch1 len 1 → that load is accepted instead.
- ch0 len 2 loaded at edge 10; `cancel[0]` at edge 18 (final tick) → no `done[0]`, `busy[0]` low from 19, `pcount` held at 0.
- ch0 len 5 and ch3 len 2 loaded at edge 10; `reset_n=0` at edge 15 → all outputs 0 from cycle 16, no `done` afterwards.
- With `TIMER_SCHED_PERIODIC_EN`: periodic ch1 len 2 loaded at edge 10 → `done[1]` at 19, 27, 35. `cancel[1]` at edge 30 → no further `done`, `busy[1]` low from 31.
